rst_sequencer: RTL and testbench



---
 rtl/rst_sequencer_if.sv | 32 +++
 rtl/rst_sequencer.sv | 151 +++++++++++++++
 tb/tb_rst_sequencer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rst_sequencer_if.sv
// Reset-sequencer signal bundle: software request and init handshake in,
// staged resets and status out. The sequencer takes the master view, the
// subsystem being reset takes the slave view.
interface rst_sequencer_if;
    logic sw_rst_req;
    logic mem_init_done;
    logic rst_mem;
    logic rst_rx;
    logic rst_tx;
    logic seq_busy;
    logic init_err;

    modport master (
        input  sw_rst_req,
        input  mem_init_done,
        output rst_mem,
        output rst_rx,
        output rst_tx,
        output seq_busy,
        output init_err
    );

    modport slave (
        output sw_rst_req,
        output mem_init_done,
        input  rst_mem,
        input  rst_rx,
        input  rst_tx,
        input  seq_busy,
        input  init_err
    );
endinterface

// File: rtl/rst_sequencer.sv
// Staged reset sequencer: releases memory, then receiver, then transmitter.
// Every output is a flop that is set asynchronously by `reset` and cleared
// only on a clock edge, so the releases are glitch-free and in order.
module rst_sequencer #(
    parameter int HOLD_CYCLES  = 16,
    parameter int GAP_CYCLES   = 4,
    parameter int INIT_TIMEOUT = 1024,
    parameter int CNT_W        = 11
) (
    input  logic             clk,
    input  logic             reset,
    rst_sequencer_if.master  bus
);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_MEM,
        ST_RX,
        ST_RUN
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_TIMEOUT - 1);

    logic [1:0]       sync_q;
    logic             rst_s;
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             init_err_q;
    logic             init_err_next;
    logic             rst_mem_q;
    logic             rst_rx_q;
    logic             rst_tx_q;
    logic             busy_q;
    logic             rst_mem_d;
    logic             rst_rx_d;
    logic             rst_tx_d;
    logic             busy_d;

    // Two-flop reset synchronizer: clears at once, fills with ones after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking so each flop captures its neighbour's pre-edge value.
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign rst_s = ~sync_q[1];

    // Next state, counter and sticky error; outputs decoded from the next state.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_next    = state;
        cnt_next      = cnt + 1'b1;
        init_err_next = init_err_q;
        rst_mem_d     = 1'b1;
        rst_rx_d      = 1'b1;
        rst_tx_d      = 1'b1;
        busy_d        = 1'b1;

        unique case (state)
            ST_HOLD: begin
                if (rst_s || bus.sw_rst_req) begin
                    cnt_next = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_next = ST_MEM;
                    cnt_next   = '0;
                end
            end
            ST_MEM: begin
                if (bus.sw_rst_req) begin
                    state_next = ST_HOLD;
                    cnt_next   = '0;
                end else if (bus.mem_init_done) begin
                    // Done wins over a timeout on the same edge.
                    state_next = ST_RX;
                    cnt_next   = '0;
                end else if (cnt == INIT_LAST) begin
                    state_next    = ST_RX;
                    cnt_next      = '0;
                    init_err_next = 1'b1;
                end
            end
            ST_RX: begin
                if (bus.sw_rst_req) begin
                    state_next = ST_HOLD;
                    cnt_next   = '0;
                end else if (cnt == GAP_LAST) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end
            end
            ST_RUN: begin
                // The counter idles in RUN; nothing times out here.
                cnt_next = cnt;
                if (bus.sw_rst_req) begin
                    state_next = ST_HOLD;
                    cnt_next   = '0;
                end
            end
        endcase

        unique case (state_next)
            ST_HOLD: ;
            ST_MEM:  rst_mem_d = 1'b0;
            ST_RX: begin
                rst_mem_d = 1'b0;
                rst_rx_d  = 1'b0;
            end
            ST_RUN: begin
                rst_mem_d = 1'b0;
                rst_rx_d  = 1'b0;
                rst_tx_d  = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State, counter, error flag and registered outputs; reset forces HOLD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_HOLD;
            cnt        <= '0;
            init_err_q <= 1'b0;
            rst_mem_q  <= 1'b1;
            rst_rx_q   <= 1'b1;
            rst_tx_q   <= 1'b1;
            busy_q     <= 1'b1;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            init_err_q <= init_err_next;
            rst_mem_q  <= rst_mem_d;
            rst_rx_q   <= rst_rx_d;
            rst_tx_q   <= rst_tx_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.rst_mem  = rst_mem_q;
    assign bus.rst_rx   = rst_rx_q;
    assign bus.rst_tx   = rst_tx_q;
    assign bus.seq_busy = busy_q;
    assign bus.init_err = init_err_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer. Edges are numbered from the first rising
// edge after `reset` falls; outputs are sampled 1 ns after each edge and
// compared as {rst_mem, rst_rx, rst_tx, seq_busy, init_err}.
module tb_rst_sequencer;

    logic clk;
    logic reset;
    int   edge_n;
    int   n_cmp;
    int   n_bad;
    int   order_viol;

    rst_sequencer_if bus ();

    rst_sequencer #(
        .HOLD_CYCLES  (16),
        .GAP_CYCLES   (4),
        .INIT_TIMEOUT (1024),
        .CNT_W        (11)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    logic [4:0] outs;
    assign outs = {bus.rst_mem, bus.rst_rx, bus.rst_tx, bus.seq_busy, bus.init_err};

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Release order and busy consistency, watched on every falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if ((!bus.rst_tx && bus.rst_rx) || (!bus.rst_rx && bus.rst_mem) ||
                (bus.seq_busy !== (bus.rst_mem | bus.rst_rx | bus.rst_tx)))
                order_viol++;
        end
    end

    // Hard stop in case the sequence never completes.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) step();
    endtask

    // Pulse reset and release it mid-cycle so the next rising edge is E1.
    task automatic do_release();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        edge_n = 0;
    endtask

    task automatic test_reset();
        reset              = 1'b1;
        bus.sw_rst_req     = 1'b0;
        bus.mem_init_done  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (outs !== 5'b11110) begin
            n_bad++;
            $display("FAIL reset_state: got %b expected %b", outs, 5'b11110);
        end
    endtask

    task automatic test_power_on();
        int         ev[7];
        logic [4:0] w[7];
        ev = '{1, 2, 17, 18, 19, 22, 23};
        w  = '{5'b11110, 5'b11110, 5'b11110, 5'b01110, 5'b00110, 5'b00110, 5'b00000};
        bus.mem_init_done = 1'b1;
        do_release();
        for (int i = 0; i < 7; i++) begin
            run_to(ev[i]);
            n_cmp++;
            if (outs !== w[i]) begin
                n_bad++;
                $display("FAIL power_on E%0d: got %b expected %b", ev[i], outs, w[i]);
            end
        end
    endtask

    task automatic test_sw_rst_run();
        int         ev[6];
        logic [4:0] w[6];
        ev = '{100, 115, 116, 117, 120, 121};
        w  = '{5'b11110, 5'b11110, 5'b01110, 5'b00110, 5'b00110, 5'b00000};
        run_to(99);
        bus.sw_rst_req = 1'b1;
        run_to(100);
        bus.sw_rst_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            run_to(ev[i]);
            n_cmp++;
            if (outs !== w[i]) begin
                n_bad++;
                $display("FAIL sw_rst_run E%0d: got %b expected %b", ev[i], outs, w[i]);
            end
        end
    endtask

    task automatic test_async_mid();
        int         ev[4];
        logic [4:0] w[4];
        ev = '{17, 18, 19, 23};
        w  = '{5'b11110, 5'b01110, 5'b00110, 5'b00000};
        bus.mem_init_done = 1'b1;
        do_release();
        run_to(21);
        n_cmp++;
        if (outs !== 5'b00110) begin
            n_bad++;
            $display("FAIL async_mid_in_rx: got %b expected %b", outs, 5'b00110);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (outs !== 5'b11110) begin
            n_bad++;
            $display("FAIL async_mid_immediate: got %b expected %b", outs, 5'b11110);
        end
        do_release();
        for (int i = 0; i < 4; i++) begin
            run_to(ev[i]);
            n_cmp++;
            if (outs !== w[i]) begin
                n_bad++;
                $display("FAIL async_mid_repeat E%0d: got %b expected %b", ev[i], outs, w[i]);
            end
        end
    endtask

    task automatic test_delayed_init();
        int         ev[4];
        logic [4:0] w[4];
        ev = '{40, 43, 44, 50};
        w  = '{5'b00110, 5'b00110, 5'b00000, 5'b00000};
        bus.mem_init_done = 1'b0;
        do_release();
        run_to(39);
        n_cmp++;
        if (outs !== 5'b01110) begin
            n_bad++;
            $display("FAIL delayed_init_wait E39: got %b expected %b", outs, 5'b01110);
        end
        bus.mem_init_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_to(ev[i]);
            n_cmp++;
            if (outs !== w[i]) begin
                n_bad++;
                $display("FAIL delayed_init E%0d: got %b expected %b", ev[i], outs, w[i]);
            end
        end
    endtask

    task automatic test_collision();
        int         ev[6];
        logic [4:0] w[6];
        ev = '{24, 30, 39, 40, 41, 45};
        w  = '{5'b11110, 5'b11110, 5'b11110, 5'b01110, 5'b00110, 5'b00000};
        bus.mem_init_done = 1'b1;
        do_release();
        run_to(18);
        n_cmp++;
        if (outs !== 5'b01110) begin
            n_bad++;
            $display("FAIL collision_mem E18: got %b expected %b", outs, 5'b01110);
        end
        bus.sw_rst_req = 1'b1;
        run_to(19);
        n_cmp++;
        if (outs !== 5'b11110) begin
            n_bad++;
            $display("FAIL collision_hold E19: got %b expected %b", outs, 5'b11110);
        end
        // Request held through E24; the HOLD count restarts from E25.
        run_to(24);
        bus.sw_rst_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            run_to(ev[i]);
            n_cmp++;
            if (outs !== w[i]) begin
                n_bad++;
                $display("FAIL collision E%0d: got %b expected %b", ev[i], outs, w[i]);
            end
        end
    endtask

    task automatic test_timeout();
        bus.mem_init_done = 1'b0;
        do_release();
        run_to(1041);
        n_cmp++;
        if (outs !== 5'b01110) begin
            n_bad++;
            $display("FAIL timeout_wait E1041: got %b expected %b", outs, 5'b01110);
        end
        run_to(1042);
        n_cmp++;
        if (outs !== 5'b00111) begin
            n_bad++;
            $display("FAIL timeout_expire E1042: got %b expected %b", outs, 5'b00111);
        end
        run_to(1046);
        n_cmp++;
        if (outs !== 5'b00001) begin
            n_bad++;
            $display("FAIL timeout_run E1046: got %b expected %b", outs, 5'b00001);
        end
        run_to(1049);
        bus.mem_init_done = 1'b1;
        run_to(1050);
        bus.mem_init_done = 1'b0;
        run_to(1052);
        n_cmp++;
        if (outs !== 5'b00001) begin
            n_bad++;
            $display("FAIL timeout_late_done E1052: got %b expected %b", outs, 5'b00001);
        end
        run_to(1059);
        bus.sw_rst_req = 1'b1;
        run_to(1060);
        bus.sw_rst_req = 1'b0;
        n_cmp++;
        if (outs !== 5'b11111) begin
            n_bad++;
            $display("FAIL timeout_sw_keeps_err E1060: got %b expected %b", outs, 5'b11111);
        end
        run_to(1076);
        n_cmp++;
        if (outs !== 5'b01111) begin
            n_bad++;
            $display("FAIL timeout_rerelease E1076: got %b expected %b", outs, 5'b01111);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (outs !== 5'b11110) begin
            n_bad++;
            $display("FAIL timeout_reset_clears E1076: got %b expected %b", outs, 5'b11110);
        end
    endtask

    task automatic test_order();
        n_cmp++;
        if (order_viol !== 0) begin
            n_bad++;
            $display("FAIL release_order: got %0d violations expected 0", order_viol);
        end
    endtask

    initial begin
        edge_n     = 0;
        n_cmp      = 0;
        n_bad      = 0;
        order_viol = 0;
        test_reset();
        test_power_on();
        test_sw_rst_run();
        test_async_mid();
        test_delayed_init();
        test_collision();
        test_timeout();
        test_order();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
